// File: rtl/snake_step_ctrl_if.sv
// Handshake bundle between the snake game logic and the step scheduler.
// The master side drives control pulses, the period and direction requests;
// the slave side (the scheduler) returns the step pulse, head position and
// game state.
interface snake_step_ctrl_if #(
  parameter int CNT_W  = 5,
  parameter int GRID_W = 5
);
  logic              start;
  logic              pause;
  logic              collide;
  logic [CNT_W-1:0]  period;
  logic [1:0]        dir_req;
  logic              dir_req_valid;
  logic              step;
  logic [1:0]        dir;
  logic [GRID_W-1:0] head_x;
  logic [GRID_W-1:0] head_y;
  logic [1:0]        state;
  logic              game_over;

  modport master (
    output start, pause, collide, period, dir_req, dir_req_valid,
    input  step, dir, head_x, head_y, state, game_over
  );

  modport slave (
    input  start, pause, collide, period, dir_req, dir_req_valid,
    output step, dir, head_x, head_y, state, game_over
  );
endinterface

// File: rtl/snake_step_ctrl.sv
// Snake game-step scheduler: divides the clock into move steps with a
// programmable tick counter, arbitrates direction requests (reversals are
// rejected against the committed direction), moves the head one cell per
// step on a toroidal grid, and owns the IDLE/RUN/PAUSED/OVER state.
module snake_step_ctrl #(
  parameter int CNT_W  = 5,
  parameter int GRID_W = 5,
  parameter int HOME_X = 8,
  parameter int HOME_Y = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  snake_step_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_OVER   = 2'b11
  } state_t;

  localparam logic [1:0]        DIR_RIGHT = 2'b01;
  localparam logic [GRID_W-1:0] HOME_X_C  = GRID_W'(HOME_X);
  localparam logic [GRID_W-1:0] HOME_Y_C  = GRID_W'(HOME_Y);
  localparam logic [GRID_W-1:0] G_ONE     = GRID_W'(1);
  localparam logic [CNT_W-1:0]  C_ONE     = CNT_W'(1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              step_q;
  logic [1:0]        dir_q;
  logic [1:0]        pend_q;
  logic [GRID_W-1:0] hx_q;
  logic [GRID_W-1:0] hy_q;
  logic              go_q;

  logic              req_ok_d;
  logic [1:0]        eff_dir_d;
  logic [GRID_W-1:0] hx_d;
  logic [GRID_W-1:0] hy_d;

  // Request legality against the committed direction, and the effective
  // direction plus the neighbouring cell the head would move to.
  always_comb begin
    req_ok_d  = 1'b0;
    eff_dir_d = pend_q;
    hx_d      = hx_q;
    hy_d      = hy_q;
    if (bus.dir_req_valid && ((state_q == S_RUN) || (state_q == S_PAUSED)) &&
        ((bus.dir_req ^ dir_q) != 2'b10)) begin
      req_ok_d = 1'b1;
    end
    if (req_ok_d) begin
      eff_dir_d = bus.dir_req;
    end
    case (eff_dir_d)
      2'b00:   hy_d = hy_q - G_ONE;
      2'b01:   hx_d = hx_q + G_ONE;
      2'b10:   hy_d = hy_q + G_ONE;
      default: hx_d = hx_q - G_ONE;
    endcase
  end

  // Game state machine, tick counter, direction and head registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= DIR_RIGHT;
      pend_q  <= DIR_RIGHT;
      hx_q    <= HOME_X_C;
      hy_q    <= HOME_Y_C;
      go_q    <= 1'b0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.collide) begin
            // Collision wins over step and pause: freeze everything.
            state_q <= S_OVER;
            go_q    <= 1'b1;
          end else if (bus.pause) begin
            state_q <= S_PAUSED;
            if (req_ok_d) begin
              pend_q <= bus.dir_req;
            end
          end else if (cnt_q == bus.period) begin
            cnt_q  <= '0;
            step_q <= 1'b1;
            dir_q  <= eff_dir_d;
            pend_q <= eff_dir_d;
            hx_q   <= hx_d;
            hy_q   <= hy_d;
          end else begin
            // A period lowered below the count wraps through zero here.
            cnt_q <= cnt_q + C_ONE;
            if (req_ok_d) begin
              pend_q <= bus.dir_req;
            end
          end
        end
        S_PAUSED: begin
          if (bus.pause) begin
            state_q <= S_RUN;
          end
          if (req_ok_d) begin
            pend_q <= bus.dir_req;
          end
        end
        S_OVER: begin
          if (bus.start) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            hx_q    <= HOME_X_C;
            hy_q    <= HOME_Y_C;
            go_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.step      = step_q;
  assign bus.dir       = dir_q;
  assign bus.head_x    = hx_q;
  assign bus.head_y    = hy_q;
  assign bus.state     = state_q;
  assign bus.game_over = go_q;

endmodule
